// File: rtl/qtr_multi_sampler.sv
// N-channel QTR RC reflectance sampler: charges enabled sensor nodes, releases them,
// and times each channel's discharge in TICK_DIV-cycle units with saturation/timeout.
module qtr_multi_sampler #(
  parameter int NUM_CH        = 2,
  parameter int CNT_WIDTH     = 8,
  parameter int CHARGE_CYCLES = 600,
  parameter int TICK_DIV      = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [NUM_CH-1:0]             ch_mask,
  output logic [NUM_CH-1:0]             qtr_out_en,
  output logic [NUM_CH-1:0]             qtr_out_sig,
  input  logic [NUM_CH-1:0]             qtr_in_sig,
  output logic [NUM_CH-1:0]             qtr_ctrl,
  output logic                          busy,
  output logic                          valid,
  output logic [NUM_CH*CNT_WIDTH-1:0]   counts,
  output logic [NUM_CH-1:0]             timeout
);

  localparam int CHG_W = $clog2(CHARGE_CYCLES) + 1;
  localparam int TK_W  = $clog2(TICK_DIV) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, CHARGE, DISCHARGE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_CH-1:0]      mask_r;
  logic [CHG_W-1:0]       charge_cnt;
  logic [TK_W-1:0]        tick_cnt;
  logic [NUM_CH-1:0]      fin;
  logic [NUM_CH-1:0]      tmo;
  logic [CNT_WIDTH-1:0]   cnt [NUM_CH];
  logic [NUM_CH-1:0]      sync_p0, sync_p1;
  logic                   tick, charge_last, load_mask, scan_entry;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser on the asynchronous pad inputs
  always_ff @(posedge clk) begin
    sync_p0 <= qtr_in_sig;
    sync_p1 <= sync_p0;
  end

  assign tick        = (tick_cnt == TK_W'(TICK_DIV - 1));
  assign charge_last = (charge_cnt == CHG_W'(CHARGE_CYCLES - 1));
  assign load_mask   = ((state == IDLE) && (start || continuous)) ||
                       ((state == DONE) && continuous);
  assign scan_entry  = (state_nxt == CHARGE) && (state != CHARGE);
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    qtr_out_en  = '0;
    qtr_out_sig = '0;
    qtr_ctrl    = '0;
    case (state)
      IDLE: begin
        if (start || continuous) state_nxt = (ch_mask == '0) ? DONE : CHARGE;
      end
      CHARGE: begin
        qtr_out_en  = mask_r;
        qtr_out_sig = mask_r;
        qtr_ctrl    = mask_r;
        if (charge_last) state_nxt = DISCHARGE;
      end
      DISCHARGE: begin
        qtr_ctrl = mask_r;
        if (&fin) state_nxt = DONE;
      end
      DONE: begin
        if (continuous) state_nxt = (ch_mask == '0) ? DONE : CHARGE;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask_r     <= '0;
      charge_cnt <= '0;
      tick_cnt   <= '0;
      fin        <= '1;
      tmo        <= '0;
      valid      <= 1'b0;
      counts     <= '0;
      timeout    <= '0;
    end else begin
      state <= state_nxt;
      valid <= (state == DONE);
      if (load_mask) mask_r <= ch_mask;
      charge_cnt <= (state == CHARGE) ? charge_cnt + 1'b1 : '0;
      tick_cnt   <= ((state == DISCHARGE) && !tick) ? tick_cnt + 1'b1 : '0;
      if (scan_entry) begin
        // Disabled channels start finished so they never hold up the scan
        fin <= ~ch_mask;
        tmo <= '0;
      end else if (state == DISCHARGE) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!fin[i]) begin
            if (!sync_p1[i]) begin
              fin[i] <= 1'b1;
            end else if (tick && (sat_inc(cnt[i]) == CNT_MAX)) begin
              fin[i] <= 1'b1;
              tmo[i] <= 1'b1;
            end
          end
        end
      end
      if (state == DONE) begin
        for (int i = 0; i < NUM_CH; i++) begin
          counts[i*CNT_WIDTH +: CNT_WIDTH] <= mask_r[i] ? cnt[i] : '0;
        end
        timeout <= tmo & mask_r;
      end
    end
  end

  // Stage p1 -> count: per-channel discharge counters (datapath, cleared per scan)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (scan_entry)
        cnt[i] <= '0;
      else if ((state == DISCHARGE) && !fin[i] && sync_p1[i] && tick)
        cnt[i] <= sat_inc(cnt[i]);
    end
  end

endmodule

// File: tb/tb_qtr_multi_sampler.sv
// Directed bench for qtr_multi_sampler with NUM_CH=2, CNT_WIDTH=4, CHARGE_CYCLES=4, TICK_DIV=2.
module tb_qtr_multi_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] ch_mask = 2'b00;
  logic [1:0] qtr_out_en, qtr_out_sig, qtr_ctrl;
  logic [1:0] qtr_in_sig = 2'b00;
  logic       busy, valid;
  logic [7:0] counts;
  logic [1:0] timeout;

  int ncmp = 0;
  int nerr = 0;

  logic watch1 = 1'b0, bad1 = 1'b0, seen0 = 1'b0;
  logic watch_any = 1'b0, bad_any = 1'b0;

  qtr_multi_sampler #(
    .NUM_CH(2), .CNT_WIDTH(4), .CHARGE_CYCLES(4), .TICK_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .qtr_out_en(qtr_out_en), .qtr_out_sig(qtr_out_sig),
    .qtr_in_sig(qtr_in_sig), .qtr_ctrl(qtr_ctrl), .busy(busy), .valid(valid),
    .counts(counts), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch1 && (qtr_out_en[1] || qtr_out_sig[1] || qtr_ctrl[1])) bad1 = 1'b1;
    if (watch1 && qtr_out_en[0]) seen0 = 1'b1;
    if (watch_any && ((qtr_out_en != 2'b00) || (qtr_out_sig != 2'b00) || (qtr_ctrl != 2'b00)))
      bad_any = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n = 0;
    while (valid !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic count_valid(input int ncyc, output int c);
    c = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (valid === 1'b1) c++;
    end
  endtask

  initial begin
    int c, n;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_valid",   {31'd0, valid}, 32'd0);
    chk("rst_pins",    {26'd0, qtr_out_en, qtr_out_sig, qtr_ctrl}, 32'd0);
    chk("rst_results", {22'd0, counts, timeout}, 32'd0);

    // Reset held 3 cycles in the middle of DISCHARGE
    ch_mask = 2'b11; qtr_in_sig = 2'b11;
    repeat (3) @(posedge clk);
    pulse_start();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_in_discharge", {30'd0, qtr_ctrl}, 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    count_valid(3, c);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_pins", {26'd0, qtr_out_en, qtr_out_sig, qtr_ctrl}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    count_valid(10, n);
    chk("rst_mid_no_valid", c + n, 32'd0);
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);
    chk("rst_mid_results", {22'd0, counts, timeout}, 32'd0);

    // Normal scan: ch1 low after 3 ticks, ch0 after 6
    qtr_in_sig = 2'b11;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 qtr_in_sig = 2'b01;
    repeat (6) @(posedge clk);
    #1 qtr_in_sig = 2'b00;
    wait_valid("norm_valid", 60);
    chk("norm_counts",  counts, 32'h36);
    chk("norm_timeout", timeout, 32'd0);
    count_valid(10, c);
    chk("norm_one_valid", c, 32'd0);

    // Saturation: ch1 held high, ch0 low after 3 ticks
    qtr_in_sig = 2'b11;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 qtr_in_sig = 2'b10;
    wait_valid("sat_valid", 100);
    chk("sat_counts",  counts, 32'hF3);
    chk("sat_timeout", timeout, 32'd2);
    count_valid(5, c);
    chk("sat_idle", {31'd0, busy}, 32'd0);
    qtr_in_sig = 2'b00;

    // Channel 1 masked off
    ch_mask = 2'b01; qtr_in_sig = 2'b11;
    repeat (3) @(posedge clk);
    watch1 = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 qtr_in_sig = 2'b10;
    wait_valid("mask01_valid", 60);
    chk("mask01_counts",  counts, 32'h03);
    chk("mask01_timeout", timeout, 32'd0);
    @(negedge clk);
    watch1 = 1'b0;
    chk("mask01_ch1_undriven", {31'd0, bad1}, 32'd0);
    chk("mask01_ch0_driven",   {31'd0, seen0}, 32'd1);
    qtr_in_sig = 2'b00;

    // Empty mask: straight to DONE
    ch_mask = 2'b00;
    repeat (3) @(posedge clk);
    watch_any = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("mask00_busy",       {31'd0, busy}, 32'd1);
    chk("mask00_valid_early", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("mask00_valid",   {31'd0, valid}, 32'd1);
    chk("mask00_results", {22'd0, counts, timeout}, 32'd0);
    @(negedge clk);
    chk("mask00_valid_end", {31'd0, valid}, 32'd0);
    watch_any = 1'b0;
    chk("mask00_undriven", {31'd0, bad_any}, 32'd0);

    // Continuous mode: three back-to-back scans, start during busy dropped
    ch_mask = 2'b11; qtr_in_sig = 2'b00;
    @(posedge clk); #1 continuous = 1'b1;
    c = 0; n = 0;
    while (c < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (valid === 1'b1) c++;
    end
    chk("cont_two_valids", c, 32'd2);
    chk("cont_recharge", {30'd0, qtr_out_en}, 32'd3);
    #1 continuous = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    count_valid(40, n);
    chk("cont_total_valids", c + n, 32'd3);
    chk("cont_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
